// File: rtl/audio_mix_pkg.sv
// Shared constants and FSM state type for the audio sample scheduler/mixer.
package audio_mix_pkg;

    localparam logic [7:0] MIDPOINT = 8'd128;
    localparam logic [7:0] AUD_MIN  = 8'd1;
    localparam logic [7:0] AUD_MAX  = 8'd255;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        MIX
    } state_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running period counter; emits a one-cycle tick each time it wraps to 0.
module sample_tick_gen #(
    parameter int SAMPLE_DIV = 256
) (
    input  logic clk,
    input  logic rst,
    output logic sample_tick
);

    localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [CW-1:0] count;

    // Tick is registered so it never fires in the first cycle after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            sample_tick <= 1'b0;
        end else if (count == CW'(SAMPLE_DIV - 1)) begin
            count       <= '0;
            sample_tick <= 1'b1;
        end else begin
            count       <= count + 1'b1;
            sample_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/audio_mix_sched.sv
// Polls NSRC audio sources once per sample period and mixes them around the
// 128 midpoint into one clamped 8-bit sample for the PWM stage.
module audio_mix_sched
    import audio_mix_pkg::*;
#(
    parameter int NSRC       = 4,
    parameter int SAMPLE_DIV = 256,
    parameter int GAIN_SHIFT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSRC-1:0]   src_enable,
    input  logic [NSRC-1:0]   src_valid,
    input  logic [8*NSRC-1:0] src_data,
    output logic [NSRC-1:0]   src_ready,
    output logic              sample_tick,
    output logic [7:0]        audio,
    output logic [NSRC-1:0]   underrun
);

    localparam int SLOT_W = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int SUM_W  = 9 + $clog2(NSRC);
    localparam int MIX_W  = SUM_W + 1;
    localparam logic signed [MIX_W-1:0] MID_S = MIX_W'(MIDPOINT);
    localparam logic signed [MIX_W-1:0] MIN_S = MIX_W'(AUD_MIN);
    localparam logic signed [MIX_W-1:0] MAX_S = MIX_W'(AUD_MAX);

    state_t             state;
    logic [SLOT_W-1:0]  slot;
    logic [7:0]         held [NSRC];
    logic [NSRC-1:0]    en_flag;

    logic signed [8:0]       term;
    logic signed [SUM_W-1:0] sum;
    logic signed [MIX_W-1:0] mixed;
    logic [7:0]              clamped;

    sample_tick_gen #(
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_tick (
        .clk        (clk),
        .rst        (rst),
        .sample_tick(sample_tick)
    );

    // Ready is decoded from the registered slot so it drops in the same
    // edge that resets the FSM and follows the enable seen in that slot.
    always_comb begin
        src_ready = '0;
        if (state == COLLECT) begin
            src_ready[slot] = src_enable[slot];
        end
    end

    always_comb begin
        term = '0;
        sum  = '0;
        for (int i = 0; i < NSRC; i++) begin
            term = $signed({1'b0, held[i]}) - 9'sd128;
            if (en_flag[i]) begin
                sum = sum + SUM_W'(term);
            end
        end
        mixed = MIX_W'(sum >>> GAIN_SHIFT) + MID_S;
        if (mixed < MIN_S) begin
            clamped = AUD_MIN;
        end else if (mixed > MAX_S) begin
            clamped = AUD_MAX;
        end else begin
            clamped = mixed[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            slot     <= '0;
            en_flag  <= '0;
            underrun <= '0;
            audio    <= MIDPOINT;
            for (int i = 0; i < NSRC; i++) begin
                held[i] <= MIDPOINT;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        state <= COLLECT;
                        slot  <= '0;
                    end
                end
                COLLECT: begin
                    en_flag[slot] <= src_enable[slot];
                    if (src_enable[slot]) begin
                        if (src_valid[slot]) begin
                            held[slot] <= src_data[int'(slot)*8 +: 8];
                        end else begin
                            underrun[slot] <= 1'b1;
                        end
                    end
                    if (slot == SLOT_W'(NSRC - 1)) begin
                        state <= MIX;
                    end else begin
                        slot <= slot + 1'b1;
                    end
                end
                MIX: begin
                    audio <= clamped;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/audio_mix_sched.md
# audio_mix_sched

Sample scheduler and mixer feeding the 8-bit PWM audio output stage. It generates the audio sample strobe at clk/SAMPLE_DIV and polls up to NSRC sound sources (speaker toggle, Mockingboard channels, and so on) in a fixed slot order using a valid/ready handshake. It mixes the collected samples around the 128 midpoint and presents one clamped sample in [1,255] that is held stable for the rest of the period.

## Interface
Parameters:
- NSRC, 4: number of sources; must satisfy NSRC+3 <= SAMPLE_DIV.
- SAMPLE_DIV, 256: clocks per sample period, matching the PWM frame.
- GAIN_SHIFT, 2: arithmetic right shift applied to the mixed sum.

Ports:
- clk  in  1  14 MHz system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- src_enable  in  NSRC  per-source enable; sampled in that source's slot.
- src_valid  in  NSRC  source i holds a sample.
- src_data  in  8*NSRC  unsigned samples, source i at bits [8i+7:8i]; 128 = silence.
- src_ready  out  NSRC  one-cycle pull strobe in source i's slot.
- sample_tick  out  1  one-cycle pulse at the start of each period.
- audio  out  8  mixed sample; always in [1,255].
- underrun  out  NSRC  sticky: enabled source was not valid in its slot.

## Operation
- Period counter:
  - Counts 0..SAMPLE_DIV-1 and wraps.
  - sample_tick is asserted in the cycle the counter is 0, except during reset.
- FSM states: IDLE, COLLECT, MIX.
  - IDLE -> COLLECT on sample_tick; the slot index is cleared to 0.
  - COLLECT, slot i, one cycle per source:
    - If src_enable[i] is set, src_ready[i] = 1.
    - If src_valid[i] is also set, the transfer completes and held[i] <= src_data[i].
    - If the source is enabled but not valid, held[i] is kept and underrun[i] <= 1.
    - A disabled source gets no ready and contributes 0 to the mix.
    - After slot NSRC-1 -> MIX.
  - MIX, one cycle:
    - sum = Σ over enabled sources of (held[i] - 128), as signed values.
    - mixed = (sum >>> GAIN_SHIFT) + 128.
    - mixed is clamped to [1,255] and registered into audio.
    - Then -> IDLE.
- Enable sampling: "enabled" in MIX means src_enable as sampled in that source's COLLECT slot; a per-slot flag is stored for this.
- Arithmetic widths:
  - Per-source terms are signed 9-bit.
  - The sum is signed, 9+clog2(NSRC) bits.
  - The shift is arithmetic (floor toward -inf).
  - The clamp is applied after adding 128.
- Held samples are consumed at most once per period. A source that stays valid across periods is pulled once per period.
- src_ready is never asserted outside COLLECT, and at most one bit is set per cycle.
- underrun bits clear only on rst.

## Timing
- Reset values, taking effect on the first clk edge with rst high:
  - audio = 128; src_ready = 0; sample_tick = 0; underrun = 0.
  - held[*] = 128; counter = 0; state = IDLE.
- First sample_tick occurs SAMPLE_DIV cycles after rst deasserts, when the counter wraps to 0.
- Schedule, with the tick at cycle T:
  - Slot i at cycle T+1+i.
  - MIX at cycle T+1+NSRC.
  - audio shows the new value from cycle T+2+NSRC.
  - With default parameters: ready at T+1..T+4, audio changes at T+6.
- audio changes only once per period. It is a single register, so there are no partial updates.
- rst during COLLECT or MIX:
  - Aborts the cycle.
  - src_ready drops at the next edge.
  - The pending sample is discarded, and audio returns to 128.
- Source-side protocol: a source must keep src_data stable while src_valid is high until it sees src_ready.

## Structure
- Package audio_mix_pkg holds:
  - MIDPOINT=128, AUD_MIN=1, AUD_MAX=255.
  - The state enum {IDLE, COLLECT, MIX}.
- Sub-module sample_tick_gen contains the period counter and sample_tick generation, with parameter SAMPLE_DIV.
- The mixer and FSM stay in audio_mix_sched.

## Test plan
Default parameters (NSRC=4, SAMPLE_DIV=256, GAIN_SHIFT=2) unless stated.
1. Reset, then release: audio=128 and src_ready=0 throughout; the first sample_tick comes exactly 256 cycles after release; src_ready[0..3] pulse at T+1..T+4.
2. All sources enabled and valid with 255 -> audio=255 at T+6. All sources at 0: sum -512 >>> 2 = -128, +128 = 0 -> clamped to audio=1.
3. Only source 1 enabled, data 200 -> (72>>>2)+128 = audio 146. Only source 1 enabled, data 1 -> (-127>>>2)+128 = audio 96, checking floor behaviour.
4. Source 2 enabled, valid=0 in its slot, previous held value 160, others disabled:
   - underrun[2] is set and stays set.
   - audio = (32>>>2)+128 = 136.
   - src_data[2] is never captured.
5. Source 0 valid held high for 3 periods -> exactly 3 transfers, one per period; src_ready[0] never high outside slot 0.
6. rst pulsed at T+3 (during slot 2):
   - src_ready=0 from the next edge, and audio=128.
   - underrun is cleared.
   - The next tick comes 256 cycles after rst deasserts.
